cond_unit: RTL and testbench

Condition-evaluation and status-flag block of the processor's execute stage. Holds the architectural flag register, written from the ALU's 4-bit `flags` output, and decides whether each issued instruction executes under its 4-bit condition field. It registers the execute/squash decision one cycle later for the write-back stage. It also gates the register-file and memory write enables downstream.

---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 117 +++++++++++
 tb/tb_cond_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code and flag definitions for the execute stage.
// The ALU op modules import this package as well.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against the
// architectural flags {Z,N,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  cond_t  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);

  logic zFlag;
  logic nFlag;
  logic cFlag;
  logic vFlag;

  assign zFlag = flags_i[FLAG_Z];
  assign nFlag = flags_i[FLAG_N];
  assign cFlag = flags_i[FLAG_C];
  assign vFlag = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = zFlag;
      COND_NE: pass_o = !zFlag;
      COND_CS: pass_o = cFlag;
      COND_CC: pass_o = !cFlag;
      COND_MI: pass_o = nFlag;
      COND_PL: pass_o = !nFlag;
      COND_VS: pass_o = vFlag;
      COND_VC: pass_o = !vFlag;
      COND_HI: pass_o = cFlag && !zFlag;
      COND_LS: pass_o = !cFlag || zFlag;
      COND_GE: pass_o = (nFlag == vFlag);
      COND_LT: pass_o = (nFlag != vFlag);
      COND_GT: pass_o = !zFlag && (nFlag == vFlag);
      COND_LE: pass_o = zFlag || (nFlag != vFlag);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage flag register and registered execute/squash decision.
// Optional saturating statistics counters are built when COND_STATS_EN is defined.
module cond_unit
  import cond_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] cond,
  input  logic       flag_wr,
  input  logic [3:0] alu_flags,
  input  logic       stall,
  input  logic       flush,
  output logic       valid_out,
  output logic       cond_ex,
  output flags_t     flags_q
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  if (CNT_W > N) begin : g_cnt_width_check
    $error("cond_unit: CNT_W must not exceed the datapath width N");
  end

  logic   pass;
  logic   accept;
  logic   valid_q;
  logic   valid_d;
  logic   ex_q;
  logic   ex_d;
  flags_t flags_d;

  // Evaluation always sees the flags as they stood before this instruction.
  cond_check u_cond_check (
    .cond_i  (cond_t'(cond)),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign accept = valid_in && !stall && !flush;

  // Flush beats stall; stall freezes everything; otherwise the decision advances.
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    flags_d = flags_q;
    if (flush) begin
      valid_d = 1'b0;
      ex_d    = 1'b0;
    end else if (!stall) begin
      valid_d = valid_in;
      ex_d    = valid_in && pass;
      if (valid_in && flag_wr && pass) begin
        flags_d = alu_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ex_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
      flags_q <= flags_d;
    end
  end

  assign valid_out = valid_q;
  assign cond_ex   = ex_q;

`ifdef COND_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] exec_d;
  logic [CNT_W-1:0] squash_q;
  logic [CNT_W-1:0] squash_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (accept && pass && (exec_q != CntMax)) begin
      exec_d = exec_q + CNT_W'(1);
    end
    if (accept && !pass && (squash_q != CntMax)) begin
      squash_d = squash_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;
`else
  logic unusedAccept;
  assign unusedAccept = accept;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; counter checks are built
// only when COND_STATS_EN is defined.
module tb_cond_unit;

  localparam int TbCntW = 4;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [3:0] cond;
  logic       flag_wr;
  logic [3:0] alu_flags;
  logic       stall;
  logic       flush;
  logic       valid_out;
  logic       cond_ex;
  logic [3:0] flags_q;
`ifdef COND_STATS_EN
  logic [TbCntW-1:0] exec_cnt;
  logic [TbCntW-1:0] squash_cnt;
`endif

  int testCount = 0;
  int failCount = 0;

  cond_unit #(.N(32), .CNT_W(TbCntW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .cond      (cond),
    .flag_wr   (flag_wr),
    .alu_flags (alu_flags),
    .stall     (stall),
    .flush     (flush),
    .valid_out (valid_out),
    .cond_ex   (cond_ex),
    .flags_q   (flags_q)
`ifdef COND_STATS_EN
    ,
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: even codes are the base test, odd codes its inverse.
  function automatic logic refPass(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cf, v, base;
    z  = f[3];
    n  = f[2];
    cf = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic fw,
                               input logic [3:0] af, input logic st, input logic fl);
    valid_in  = v;
    cond      = c;
    flag_wr   = fw;
    alu_flags = af;
    stall     = st;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic e,
                          input logic [3:0] f);
    checkOutput({tag, "_valid"}, 16'(valid_out), 16'(v));
    checkOutput({tag, "_ex"}, 16'(cond_ex), 16'(e));
    checkOutput({tag, "_flags"}, 16'(flags_q), 16'(f));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("reset", 1'b0, 1'b0, 4'b0000);
`ifdef COND_STATS_EN
    checkOutput("reset_exec_cnt", 16'(exec_cnt), 16'd0);
    checkOutput("reset_squash_cnt", 16'(squash_cnt), 16'd0);
`endif

    // EQ fails with Z clear, so its flag write is discarded.
    rst = 1'b0;
    applyStimulus(1'b1, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0);
    tick();
    checkAll("eq_fail", 1'b1, 1'b0, 4'b0000);

    // AL sets Z, then a back-to-back EQ sees the new Z.
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b1000, 1'b0, 1'b0);
    tick();
    checkAll("al_setz", 1'b1, 1'b1, 4'b1000);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    checkAll("eq_pass", 1'b1, 1'b1, 4'b1000);

    // Full condition/flag sweep.
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = f[3:0];
      applyStimulus(1'b1, 4'b1110, 1'b1, fv, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("sweep_load_f%0d", f), 16'(flags_q), 16'(fv));
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cv;
        cv = c[3:0];
        applyStimulus(1'b1, cv, 1'b0, ~fv, 1'b0, 1'b0);
        tick();
        checkOutput($sformatf("sweep_c%0d_f%0d", c, f), 16'(cond_ex), 16'(refPass(cv, fv)));
      end
      checkOutput($sformatf("sweep_hold_f%0d", f), 16'(flags_q), 16'(fv));
    end

    applyStimulus(1'b0, 4'b1110, 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkAll("idle", 1'b0, 1'b0, 4'b1111);

    // A failing NV leaves valid_out=1, cond_ex=0 as the state to freeze.
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkAll("nv_fail", 1'b1, 1'b0, 4'b1111);

    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("stall%0d", i), 1'b1, 1'b0, 4'b1111);
    end
    stall = 1'b0;
    tick();
    checkAll("stall_release", 1'b1, 1'b1, 4'b0100);

    // Flush wins over stall, and flush alone also kills the flag write.
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0011, 1'b1, 1'b1);
    tick();
    checkAll("flush_stall", 1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0001, 1'b0, 1'b1);
    tick();
    checkAll("flush_only", 1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0010, 1'b0, 1'b0);
    tick();
    checkAll("after_flush", 1'b1, 1'b1, 4'b0010);

    // Reset right after a flag write, with stall and flush also asserted.
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b1010, 1'b0, 1'b0);
    tick();
    checkAll("pre_reset", 1'b1, 1'b1, 4'b1010);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0101, 1'b1, 1'b1);
    tick();
    checkAll("mid_reset", 1'b0, 1'b0, 4'b0000);
`ifdef COND_STATS_EN
    checkOutput("mid_reset_exec_cnt", 16'(exec_cnt), 16'd0);
    checkOutput("mid_reset_squash_cnt", 16'(squash_cnt), 16'd0);
`endif
    rst = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    checkAll("post_reset_ne", 1'b1, 1'b1, 4'b0000);

`ifdef COND_STATS_EN
    // Drive exec_cnt to all-ones and beyond; it must stick.
    applyStimulus(1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("exec_sat", 16'(exec_cnt), 16'd15);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("squash_cnt3", 16'(squash_cnt), 16'd3);
    checkOutput("exec_still_sat", 16'(exec_cnt), 16'd15);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("squash_stall_hold", 16'(squash_cnt), 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
